// File: rtl/vector_divider_16bit_pkg.sv
// Shared types and constants for the vector divider: FSM states, precision
// encoding and the iteration count for each lane configuration.
package vdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } vdiv_state_t;

    localparam logic [1:0] PREC_8BIT = 2'b00;
    localparam int         ITER_16   = 16;
    localparam int         ITER_8    = 8;

    // Number of restoring steps needed for a given precision code.
    function automatic logic [4:0] iter_count(input logic [1:0] prec);
        return (prec == PREC_8BIT) ? 5'(ITER_8) : 5'(ITER_16);
    endfunction

endpackage

// File: rtl/vector_divider_16bit_div_lane_step.sv
// One combinational radix-2 restoring division step for a WIDTH-bit lane.
// The dividend shift register feeds its MSB into the partial remainder and
// collects quotient bits at its LSB, so after WIDTH steps it holds the quotient.
module div_lane_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] shift_out
);

    logic [WIDTH:0] trial;
    logic           q_bit;

    // Shift, compare against the divisor, subtract when it fits; a zero divisor
    // always fits, which yields an all-ones quotient and remainder = dividend.
    always_comb begin
        trial     = {rem_in, shift_in[WIDTH-1]};
        q_bit     = (trial >= {1'b0, divisor});
        rem_out   = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
        shift_out = {shift_in[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/vector_divider_16bit.sv
// Sequential unsigned vector divider: two 8-bit lanes or one 16-bit lane,
// one quotient bit per lane per cycle, valid/ready on both sides.
module vector_divider_16bit
    import vdiv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   operand_a_16bit,
    input  logic [DATA_WIDTH-1:0]   operand_b_16bit,
    input  logic [1:0]              precision,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] output_16bit_div,
    output logic [1:0]              div_by_zero
);

    vdiv_state_t           state, next_state;
    logic                  ready_en;
    logic [DATA_WIDTH-1:0] rem_q, shift_q, div_q;
    logic [DATA_WIDTH-1:0] rem_next, shift_next;
    logic [1:0]            prec_q;
    logic [4:0]            count_q;
    logic [1:0]            zero_flags;

    logic [LANE_WIDTH-1:0] rem_l0, shift_l0, rem_l1, shift_l1;
    logic [DATA_WIDTH-1:0] rem_w, shift_w;

    div_lane_step #(.WIDTH(LANE_WIDTH)) u_lane0 (
        .rem_in    (rem_q[LANE_WIDTH-1:0]),
        .shift_in  (shift_q[LANE_WIDTH-1:0]),
        .divisor   (div_q[LANE_WIDTH-1:0]),
        .rem_out   (rem_l0),
        .shift_out (shift_l0)
    );

    div_lane_step #(.WIDTH(LANE_WIDTH)) u_lane1 (
        .rem_in    (rem_q[DATA_WIDTH-1:LANE_WIDTH]),
        .shift_in  (shift_q[DATA_WIDTH-1:LANE_WIDTH]),
        .divisor   (div_q[DATA_WIDTH-1:LANE_WIDTH]),
        .rem_out   (rem_l1),
        .shift_out (shift_l1)
    );

    div_lane_step #(.WIDTH(DATA_WIDTH)) u_wide (
        .rem_in    (rem_q),
        .shift_in  (shift_q),
        .divisor   (div_q),
        .rem_out   (rem_w),
        .shift_out (shift_w)
    );

    // Latched precision picks split-lane or full-width step results.
    always_comb begin
        rem_next   = rem_w;
        shift_next = shift_w;
        if (prec_q == PREC_8BIT) begin
            rem_next   = {rem_l1, rem_l0};
            shift_next = {shift_l1, shift_l0};
        end
    end

    // Per-lane divisor zero detect on the latched divisor.
    always_comb begin
        zero_flags = {2{div_q == '0}};
        if (prec_q == PREC_8BIT) begin
            zero_flags = {div_q[DATA_WIDTH-1:LANE_WIDTH] == '0,
                          div_q[LANE_WIDTH-1:0] == '0};
        end
    end

    // in_ready is held low through reset and for the first edge after release.
    assign in_ready = (state == IDLE) && ready_en;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: accept, iterate until the last step, hold until taken.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && in_ready) next_state = BUSY;
            BUSY:    if (count_q == 5'd1)      next_state = DONE;
            DONE:    if (out_ready)            next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, per-cycle iteration, and registered result/flag/valid outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en         <= 1'b0;
            rem_q            <= '0;
            shift_q          <= '0;
            div_q            <= '0;
            prec_q           <= '0;
            count_q          <= '0;
            output_16bit_div <= '0;
            div_by_zero      <= '0;
            out_valid        <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rem_q   <= '0;
                        shift_q <= operand_a_16bit;
                        div_q   <= operand_b_16bit;
                        prec_q  <= precision;
                        count_q <= iter_count(precision);
                    end
                end
                BUSY: begin
                    rem_q   <= rem_next;
                    shift_q <= shift_next;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        output_16bit_div <= {rem_next, shift_next};
                        div_by_zero      <= zero_flags;
                        out_valid        <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
